// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the ram_arbiter and the RAM model.
// The arbiter takes the slave view; the requester/RAM environment takes the master view.
interface ram_arbiter_if #(
   parameter int WORD_W = 32
);
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;

   logic              dREN;
   logic              dWEN;
   logic              datomic;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;

   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic              ram_ready;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ram_ready,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ram_ready,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-ported RAM between instruction fetch and data access, alternating
// priority under contention, and holds the LL/SC reservation.
module ram_arbiter #(
   parameter int WORD_W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   ram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      IACC,
      DACC,
      SCFAIL
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              last_d;
   logic              link_valid;
   logic [WORD_W-1:0] link_addr;

   logic              dreq;
   logic              sc_fail;
   logic              i_done;
   logic              d_done;

   assign dreq    = bus.dREN | bus.dWEN;
   // An SC can only succeed while the reservation still covers its address.
   assign sc_fail = bus.dWEN & bus.datomic & (~link_valid | (link_addr != bus.daddr));

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred on any path.
      next_state   = state;
      i_done       = 1'b0;
      d_done       = 1'b0;
      bus.iwait    = 1'b1;
      bus.iload    = '0;
      bus.dwait    = 1'b1;
      bus.dload    = '0;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;

      unique case (state)
         IDLE: begin
            if (dreq && sc_fail)                    next_state = SCFAIL;
            else if (dreq && (!bus.iREN || !last_d)) next_state = DACC;
            else if (bus.iREN)                      next_state = IACC;
         end

         IACC: begin
            bus.ramREN  = bus.iREN;
            bus.ramaddr = bus.iaddr;
            if (!bus.iREN) begin
               next_state = IDLE;
            end else if (bus.ram_ready) begin
               i_done     = 1'b1;
               bus.iwait  = 1'b0;
               bus.iload  = bus.ramload;
               next_state = IDLE;
            end
         end

         DACC: begin
            bus.ramREN   = bus.dREN;
            bus.ramWEN   = bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            if (!dreq) begin
               next_state = IDLE;
            end else if (bus.ram_ready) begin
               d_done     = 1'b1;
               bus.dwait  = 1'b0;
               next_state = IDLE;
               if (bus.dWEN && bus.datomic) bus.dload = WORD_W'(1);
               else if (bus.dREN)           bus.dload = bus.ramload;
            end
         end

         SCFAIL: begin
            d_done     = 1'b1;
            bus.dwait  = 1'b0;
            next_state = IDLE;
         end

         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (RST) begin
         state      <= IDLE;
         last_d     <= 1'b0;
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else begin
         state <= next_state;
         if (i_done) last_d <= 1'b0;
         if (d_done) last_d <= 1'b1;

         if (state == SCFAIL) begin
            link_valid <= 1'b0;
         end else if (d_done) begin
            if (bus.dREN && bus.datomic) begin
               link_valid <= 1'b1;
               link_addr  <= bus.daddr;
            end else if (bus.dWEN && (bus.datomic || bus.daddr == link_addr)) begin
               link_valid <= 1'b0;
            end
         end
      end
   end

endmodule
